// File: rtl/bcd4tobin4_pkg.sv
// Shared types and constants for the 4-digit BCD <-> binary converters.
package bcd4tobin4_pkg;

    localparam int unsigned NDigits = 4;
    localparam int unsigned BinW    = 16;
    localparam int unsigned NIter   = 16;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        StIdle,
        StOp,
        StDone
    } state_e;

    function automatic logic digit_valid(input bcd_digit_t d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd4tobin4_dec3.sv
// Reverse double-dabble nibble correction: subtract 3 from any digit that is 8 or more.
module bcd4tobin4_dec3
    import bcd4tobin4_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    always_comb begin
        digit_o = (digit_i >= 4'd8) ? digit_i - 4'd3 : digit_i;
    end

endmodule

// File: rtl/bcd4tobin4.sv
// Sequential 4-digit BCD to 16-bit binary converter (reverse double dabble, 16 iterations)
// with a start/ready/done handshake.
module bcd4tobin4
    import bcd4tobin4_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  bcd_digit_t      i_bcd3,
    input  bcd_digit_t      i_bcd2,
    input  bcd_digit_t      i_bcd1,
    input  bcd_digit_t      i_bcd0,
    output logic            o_ready,
    output logic            o_done,
    output logic [BinW-1:0] o_bin,
    output logic            o_err
);

    state_e                 state_q, state_d;
    logic [4*NDigits-1:0]   bcd_q, bcd_d;
    logic [BinW-1:0]        bin_q, bin_d;
    logic [3:0]             n_q, n_d;
    logic [BinW-1:0]        obin_q, obin_d;
    logic                   err_q, err_d;

    logic [4*NDigits-1:0]   bcd_shift, bcd_adj;
    logic [BinW-1:0]        bin_shift;
    logic                   digits_ok;

    // One right shift of the combined {bcd, bin} register; bcd LSB enters bin MSB.
    assign {bcd_shift, bin_shift} = {bcd_q, bin_q} >> 1;

    for (genvar g = 0; g < NDigits; g++) begin : g_dec
        bcd4tobin4_dec3 u_dec3 (
            .digit_i (bcd_shift[4*g +: 4]),
            .digit_o (bcd_adj[4*g +: 4])
        );
    end

    assign digits_ok = digit_valid(i_bcd3) && digit_valid(i_bcd2) &&
                       digit_valid(i_bcd1) && digit_valid(i_bcd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            bcd_q   <= '0;
            bin_q   <= '0;
            n_q     <= '0;
            obin_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            n_q     <= n_d;
            obin_q  <= obin_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        n_d     = n_q;
        obin_d  = obin_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    if (digits_ok) begin
                        bcd_d   = {i_bcd3, i_bcd2, i_bcd1, i_bcd0};
                        bin_d   = '0;
                        n_d     = 4'(NIter - 1);
                        err_d   = 1'b0;
                        state_d = StOp;
                    end else begin
                        obin_d  = '0;
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StOp: begin
                bcd_d = bcd_adj;
                bin_d = bin_shift;
                n_d   = n_q - 4'd1;
                if (n_q == 4'd0) begin
                    obin_d  = bin_shift;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_ready = (state_q == StIdle);
        o_done  = (state_q == StDone);
        o_bin   = obin_q;
        o_err   = err_q;
    end

endmodule

// File: tb/tb_bcd4tobin4.sv
// Randomized self-checking bench for bcd4tobin4 against an arithmetic reference model.
module tb_bcd4tobin4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  b3, b2, b1, b0;
    logic        ready, done, err;
    logic [15:0] bin;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    bcd4tobin4 u_dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_bcd3  (b3),
        .i_bcd2  (b2),
        .i_bcd1  (b1),
        .i_bcd0  (b0),
        .o_ready (ready),
        .o_done  (done),
        .o_bin   (bin),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int t = 0;
        while (!ready && t < 60) begin
            step();
            t++;
        end
        chk({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    // Issue one request; lat counts cycles from the accepting edge to the o_done cycle.
    task automatic do_req(input string tag, input logic [3:0] d3, input logic [3:0] d2,
                          input logic [3:0] d1, input logic [3:0] d0, output int lat);
        wait_ready(tag);
        {b3, b2, b1, b0} = {d3, d2, d1, d0};
        start = 1'b1;
        step();
        start = 1'b0;
        {b3, b2, b1, b0} = 16'hFFFF;
        lat = 1;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic check_req(input string tag, input logic [3:0] d3, input logic [3:0] d2,
                             input logic [3:0] d1, input logic [3:0] d0);
        int lat;
        int val;
        int rt;
        logic ok;
        logic [15:0] held;
        ok  = (d3 <= 9) && (d2 <= 9) && (d1 <= 9) && (d0 <= 9);
        val = ok ? int'(d3) * 1000 + int'(d2) * 100 + int'(d1) * 10 + int'(d0) : 0;
        do_req(tag, d3, d2, d1, d0, lat);
        chk({tag, "_lat"}, 32'(lat), ok ? 32'd17 : 32'd1);
        chk({tag, "_bin"}, 32'(bin), 32'(val));
        chk({tag, "_err"}, 32'(err), 32'(!ok));
        if (ok) begin
            rt = ((int'(bin) / 1000) % 10) * 4096 + ((int'(bin) / 100) % 10) * 256 +
                 ((int'(bin) / 10) % 10) * 16 + (int'(bin) % 10);
            chk({tag, "_rtrip"}, 32'(rt), 32'({d3, d2, d1, d0}));
        end
        held = bin;
        step();
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, 32'(bin), 32'(held));
    endtask

    initial begin
        int dones;
        logic [15:0] seen;

        rst   = 1'b1;
        start = 1'b0;
        {b3, b2, b1, b0} = '0;
        step();
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bin", 32'(bin), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        check_req("d0000", 4'd0, 4'd0, 4'd0, 4'd0);
        check_req("d1234", 4'd1, 4'd2, 4'd3, 4'd4);
        check_req("d9999", 4'd9, 4'd9, 4'd9, 4'd9);
        check_req("d0008", 4'd0, 4'd0, 4'd0, 4'd8);
        check_req("d1000", 4'd1, 4'd0, 4'd0, 4'd0);
        check_req("inval", 4'd0, 4'd0, 4'hA, 4'd1);
        check_req("d0010", 4'd0, 4'd0, 4'd1, 4'd0);

        // Start pulse during OP must be ignored.
        wait_ready("busy");
        {b3, b2, b1, b0} = 16'h1234;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        {b3, b2, b1, b0} = 16'h9876;
        start = 1'b1;
        step();
        start = 1'b0;
        dones = 0;
        seen  = '0;
        repeat (30) begin
            if (done) begin
                dones++;
                seen = bin;
            end
            step();
        end
        chk("busy_dones", 32'(dones), 32'd1);
        chk("busy_bin", 32'(seen), 32'h04D2);

        // Reset in the middle of OP aborts silently.
        wait_ready("abort");
        {b3, b2, b1, b0} = 16'h0123;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_bin", 32'(bin), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        dones = 0;
        repeat (25) begin
            if (done) dones++;
            step();
        end
        chk("abort_dones", 32'(dones), 32'd0);
        check_req("d0042", 4'd0, 4'd0, 4'd4, 4'd2);

        // Held start re-triggers on every IDLE cycle.
        wait_ready("held");
        {b3, b2, b1, b0} = 16'h0015;
        start = 1'b1;
        dones = 0;
        repeat (40) begin
            step();
            if (done) begin
                dones++;
                chk("held_bin", 32'(bin), 32'd15);
            end
        end
        start = 1'b0;
        chk("held_dones", 32'(dones), 32'd2);
        wait_ready("held_end");

        for (int i = 0; i < 300; i++) begin
            check_req("rnd", 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
        end
        for (int i = 0; i < 40; i++) begin
            check_req("rndx", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
